// File: rtl/vector_magnitude.sv
// vector_magnitude: floor square root of dot(op, op) in signed Q format,
// found by a bit-serial trial search, one result bit per SEARCH cycle.
// Optional build macro VECTOR_MAGNITUDE_EARLY_EXIT_EN: a zero dot product
// skips the search and completes in one cycle.
`ifndef FIXED_W
`define FIXED_W 32
`endif
`ifndef FIXED_FRACTION_W
`define FIXED_FRACTION_W 16
`endif

package fixed_point;
  localparam int unsigned FIXED_W          = `FIXED_W;
  localparam int unsigned FIXED_FRACTION_W = `FIXED_FRACTION_W;
  typedef logic signed [FIXED_W-1:0] fixed_point_t;
endpackage

package vector;
  typedef struct packed {
    fixed_point::fixed_point_t x;
    fixed_point::fixed_point_t y;
    fixed_point::fixed_point_t z;
  } vector_t;
endpackage

// Q-format dot product: exact sum of full products, then one floor rescale.
module vector_dot_product
  import fixed_point::*;
(
  input  vector::vector_t i_a,
  input  vector::vector_t i_b,
  output fixed_point_t    o_dot,
  output logic            o_overflow
);
  localparam int unsigned W  = FIXED_W;
  localparam int unsigned F  = FIXED_FRACTION_W;
  localparam int unsigned PW = 2 * W;
  localparam int unsigned SW = PW + 2;

  logic signed [PW-1:0] w_px;
  logic signed [PW-1:0] w_py;
  logic signed [PW-1:0] w_pz;
  logic signed [SW-1:0] w_sum;
  logic signed [SW-1:0] w_scaled;
  logic [SW-W:0]        w_top;

  assign w_px     = PW'(i_a.x) * PW'(i_b.x);
  assign w_py     = PW'(i_a.y) * PW'(i_b.y);
  assign w_pz     = PW'(i_a.z) * PW'(i_b.z);
  assign w_sum    = SW'(w_px) + SW'(w_py) + SW'(w_pz);
  assign w_scaled = w_sum >>> F;
  // Result fits only if everything above the sign bit is a sign extension.
  assign w_top      = w_scaled[SW-1:W-1];
  assign o_overflow = !((&w_top) || !(|w_top));
  assign o_dot      = w_scaled[W-1:0];
endmodule

module vector_magnitude
  import fixed_point::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  vector::vector_t i_op,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  output fixed_point_t    o_result,
  output logic            o_overflow,
  output logic            o_out_valid,
  input  logic            i_out_ready
);
  localparam int unsigned W       = FIXED_W;
  localparam int unsigned F       = FIXED_FRACTION_W;
  localparam int unsigned DW      = 2 * W;
  localparam int unsigned KW      = $clog2(W);
  localparam logic [KW-1:0] K_START = KW'(W - 2);
  localparam logic [W-1:0]  MAX_POS = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [W-1:0]  r_d;
  logic [W-1:0]  r_m;
  logic [KW-1:0] r_k;
  logic          r_overflow;
  fixed_point_t  w_dot;
  logic          w_dot_ovf;
  logic [W-1:0]  w_t;
  logic [DW-1:0] w_tt;
  logic [DW-1:0] w_dlim;
  logic          w_fit;
`ifdef VECTOR_MAGNITUDE_EARLY_EXIT_EN
  logic          w_zero;
  assign w_zero = (w_dot == '0);
`endif

  vector_dot_product u_dot (
    .i_a        (i_op),
    .i_b        (i_op),
    .o_dot      (w_dot),
    .o_overflow (w_dot_ovf)
  );

  // Trial bit test: t*t against d rescaled to the square's fraction width.
  assign w_t    = r_m | (W'(1) << r_k);
  assign w_tt   = DW'(w_t) * DW'(w_t);
  assign w_dlim = DW'(r_d) << F;
  assign w_fit  = (w_tt <= w_dlim);

  assign o_in_ready  = (r_state == IDLE);
  assign o_out_valid = (r_state == DONE);
  assign o_result    = r_m;
  assign o_overflow  = r_overflow;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (i_in_valid) begin
          if (w_dot_ovf) w_state_next = DONE;
`ifdef VECTOR_MAGNITUDE_EARLY_EXIT_EN
          else if (w_zero) w_state_next = DONE;
`endif
          else w_state_next = SEARCH;
        end
      end
      SEARCH:  if (r_k == '0) w_state_next = DONE;
      DONE:    if (i_out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Operand capture and one-bit-per-cycle root search.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d        <= '0;
      r_m        <= '0;
      r_k        <= '0;
      r_overflow <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_in_valid) begin
            r_d        <= w_dot;
            r_k        <= K_START;
            r_overflow <= w_dot_ovf;
            r_m        <= w_dot_ovf ? MAX_POS : '0;
          end
        end
        SEARCH: begin
          if (w_fit) r_m <= w_t;
          r_k <= (r_k == '0) ? '0 : r_k - KW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/vector_magnitude.md
VECTOR_MAGNITUDE -- requirements
Module: vector_magnitude

Interface
REQ-001 Parameters: none; all widths SHALL come from `FIXED_W and `FIXED_FRACTION_W (fixed_point package).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 op  input  vector::vector_t  operand vector; sampled only on acceptance.
REQ-005 in_valid  input  1  op is valid.
REQ-006 in_ready  output  1  block can accept op.
REQ-007 result  output  fixed_point_t  magnitude of accepted vector, non-negative.
REQ-008 overflow  output  1  squared magnitude overflowed; result saturated.
REQ-009 out_valid  output  1  result and overflow are valid.
REQ-010 out_ready  input  1  consumer accepts result.

Function
REQ-011 Acceptance SHALL occur on a rising edge where in_valid and in_ready are both 1; the block SHALL then register d = dot(op, op) and its overflow flag, using vector_dot_product.
REQ-012 FSM states SHALL be IDLE, SEARCH and DONE.
REQ-013 IDLE: in_ready=1, out_valid=0. On acceptance, the block SHALL go to DONE if the dot overflow flag is set. Otherwise it SHALL go to SEARCH with m=0 and k=`FIXED_W-2.
REQ-014 SEARCH: in_ready=0, out_valid=0. Each cycle the block SHALL form trial t = m | (1<<k).
REQ-015 SEARCH: the block SHALL compute the full 2*`FIXED_W-bit unsigned product t*t with no truncation, and set m=t if t*t <= (d << `FIXED_FRACTION_W).
REQ-016 SEARCH: the block SHALL then decrement k. After the k=0 step it SHALL go to DONE. SEARCH SHALL last exactly `FIXED_W-1 cycles.
REQ-017 result SHALL be the largest non-negative fixed-point m with m*m <= d (floor square root in Q format); the sign bit SHALL always be 0.
REQ-018 On dot overflow, result SHALL be the maximum positive value (0 sign bit, all other bits 1) and overflow SHALL be 1; otherwise overflow SHALL be 0.
REQ-019 DONE: out_valid=1, in_ready=0. result and overflow SHALL be held stable until a rising edge with out_ready=1, after which the FSM SHALL return to IDLE.
REQ-020 Back-to-back: after the out handshake, in_ready SHALL rise one cycle later. No input SHALL be accepted in the same cycle as an output handshake.
REQ-021 Latency SHALL be `FIXED_W cycles from the acceptance edge to out_valid high in the normal case, and 1 cycle in the overflow case.
REQ-022 Changes of op or in_valid outside acceptance SHALL have no effect on an operation in progress.
REQ-023 All outputs SHALL be registered or decoded purely from FSM state; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, in_ready=1, out_valid=0, result=0, overflow=0, m=0 and k=0, regardless of state.
REQ-025 Reset asserted mid-SEARCH or mid-DONE SHALL discard the operation; no out_valid pulse SHALL follow the reset release.

Configuration
REQ-026 Macro VECTOR_MAGNITUDE_EARLY_EXIT_EN defined: on acceptance with d=0 and no overflow, the FSM SHALL go directly to DONE with result=0 (latency 1 cycle).
REQ-027 Macro VECTOR_MAGNITUDE_EARLY_EXIT_EN undefined: d=0 SHALL take the full SEARCH path (latency `FIXED_W) and yield result=0.

Verification (bench: `FIXED_W=32, `FIXED_FRACTION_W=16)
REQ-028 op=(3.0,4.0,0.0), out_ready=1 -> out_valid 32 cycles after acceptance, result=0x00050000, overflow=0.
REQ-029 op=(1.0,0.0,0.0) then op=(0.0,0.0,2.0) back-to-back -> results 0x00010000 then 0x00020000. The second op SHALL be accepted only after in_ready returns.
REQ-030 op=(0,0,0) -> result=0; out_valid 1 cycle after acceptance with VECTOR_MAGNITUDE_EARLY_EXIT_EN, 32 cycles without.
REQ-031 op=(0.0,0.0,256.0) (dot overflows) -> overflow=1, result=0x7FFFFFFF, out_valid 1 cycle after acceptance.
REQ-032 out_ready held low 10 cycles in DONE -> result, overflow and out_valid stable, in_ready=0. out_ready=1 -> IDLE next cycle.
REQ-033 rst_n pulsed low 10 cycles into SEARCH -> out_valid=0 and in_ready=1 immediately. A subsequent op=(3.0,4.0,0.0) SHALL still give 0x00050000.
